muldiv_ctrl: RTL
================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL provide: clk  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL provide: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL provide: op_valid  in  1  decode presents a HI/LO-writing op this cycle.
REQ-004 SHALL provide: op  in  2  00 MULTU, 01 MULT (signed), 10 MTHI, 11 MTLO.
REQ-005 SHALL provide: rs_val  in  32  first operand / MTHI-MTLO source.
REQ-006 SHALL provide: rt_val  in  32  second operand.
REQ-007 SHALL provide: rd_req  in  1  decode requests MFHI/MFLO this cycle.
REQ-008 SHALL provide: rd_sel  in  1  0 = LO, 1 = HI.
REQ-009 SHALL provide: rd_data  out  32  selected HI/LO value, combinational.
REQ-010 SHALL provide: stall  out  1  pipeline hold request.
REQ-011 SHALL provide: hi, lo  out  32 each  architectural HI/LO registers.
REQ-012 SHALL provide: mul_start  out  1  one-cycle start pulse to unsigned multiplier.
REQ-013 SHALL provide: mul_a, mul_b  out  32 each  registered multiplier operands.
REQ-014 SHALL provide: mul_busy  in  1  multiplier busy flag.
REQ-015 SHALL provide: mul_result  in  64  unsigned product, valid once mul_busy falls.

Function
REQ-016 SHALL implement states IDLE, WAIT_FREE, ISSUE, ARM, RUN, FIX.
REQ-017 IDLE, op_valid, op=MTHI/MTLO: SHALL write rs_val to hi/lo at the edge; no stall; remain IDLE.
REQ-018 IDLE, op_valid, op=MULT/MULTU: SHALL latch operands, go to ISSUE if mul_busy=0, else WAIT_FREE.
REQ-019 WAIT_FREE: SHALL stay until mul_busy=0, then ISSUE.
REQ-020 Operand latch: MULTU passes rs/rt unchanged; MULT latches |rs|, |rt| and neg = rs[31]^rt[31]; |0x80000000| = 0x80000000 unsigned.
REQ-021 ISSUE: mul_start=1 for exactly one cycle; next state ARM; mul_a/mul_b stable from ISSUE through RUN.
REQ-022 ARM: 2-bit counter cleared on entry; mul_busy=1 -> RUN; counter reaching 3 with mul_busy=0 -> FIX (zero-latency multiplier).
REQ-023 RUN: SHALL wait for mul_busy=0, then FIX.
REQ-024 FIX: SHALL write {hi,lo} = neg ? (~mul_result + 1) mod 2^64 : mul_result; return IDLE.
REQ-025 Op latency: ISSUE to hi/lo update = multiplier busy length + 3 cycles; hi/lo unchanged until FIX edge.
REQ-026 stall SHALL be 1 when state != IDLE and (op_valid or rd_req); else 0.
REQ-027 New op_valid while state != IDLE SHALL be ignored (decode holds it under stall).
REQ-028 rd_data SHALL be rd_sel ? hi : lo, and reflect an MTHI/MTLO only from the cycle after its write.
REQ-029 Simultaneous op_valid (MTHI/MTLO) and rd_req in IDLE: rd_data returns pre-write value; no stall.

Reset
REQ-030 reset=1 SHALL force state IDLE, hi=0, lo=0, mul_start=0, mul_a=0, mul_b=0, neg=0, counter=0.
REQ-031 Reset mid-operation SHALL abandon the op; hi/lo=0; a still-busy multiplier is drained via WAIT_FREE before the next ISSUE.
REQ-032 reset SHALL take priority over op_valid in the same cycle.

Verification
REQ-033 MULTU rs=0xFFFFFFFF rt=3 -> hi=0x00000002, lo=0xFFFFFFFD; exactly one mul_start pulse.
REQ-034 MULT rs=0xFFFFFFFE rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFF2; mul_a=2, mul_b=7.
REQ-035 MULT rs=rt=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-036 MULTU 55*3 with rd_req held during op -> stall=1 until FIX edge; then rd_sel=0 gives 0x000000A5 with stall=0.
REQ-037 MTHI 0x12345678 then MFHI next cycle -> rd_data=0x12345678, stall never asserted.
REQ-038 reset in RUN with mul_busy held high 5 more cycles, then MULTU 2*3 -> WAIT_FREE until busy low, then hi=0, lo=6.

Source files
------------

// File: rtl/muldiv_ctrl_if.sv
// HI/LO unit bus: decode-side op/read channel plus the multiplier handshake.
// Latency: none (wires only).
// Backpressure: stall travels from the controller back to decode; mul_busy travels from the multiplier to the controller.
interface muldiv_ctrl_if;
    // decode -> controller
    logic        op_valid;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        rd_req;
    logic        rd_sel;
    // controller -> decode
    logic [31:0] rd_data;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    // controller <-> unsigned multiplier
    logic        mul_start;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_busy;
    logic [63:0] mul_result;

    // Environment side: decode stage plus the multiplier.
    modport master (
        output op_valid, op, rs_val, rt_val, rd_req, rd_sel, mul_busy, mul_result,
        input  rd_data, stall, hi, lo, mul_start, mul_a, mul_b
    );

    // Controller side.
    modport slave (
        input  op_valid, op, rs_val, rt_val, rd_req, rd_sel, mul_busy, mul_result,
        output rd_data, stall, hi, lo, mul_start, mul_a, mul_b
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// HI/LO controller: MTHI/MTLO writes, and MULT/MULTU sequencing around an external unsigned multiplier.
// Latency: MTHI/MTLO take effect the next cycle. A multiply writes HI/LO busy length + 3 cycles after ISSUE.
// Backpressure: stall is raised while not IDLE and decode is presenting an op or a read; mul_busy gates ISSUE.
module muldiv_ctrl (
    input  logic          clk,
    input  logic          reset,
    muldiv_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_FREE = 3'd1,
        ISSUE     = 3'd2,
        ARM       = 3'd3,
        RUN       = 3'd4,
        FIX       = 3'd5
    } state_t;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;
    localparam logic [1:0] OP_MTLO  = 2'b11;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        neg_q;
    logic [1:0]  cnt_q;
    logic        start_q;

    logic        is_mul;
    logic        is_mt;
    logic        is_signed;
    logic [31:0] abs_rs;
    logic [31:0] abs_rt;
    logic        neg_in;
    logic [63:0] fixed_prod;

    // Only ops accepted in IDLE matter; anything presented while busy is
    // held by decode under stall and re-presented once IDLE is reached.
    assign is_mul    = bus.op_valid && ((bus.op == OP_MULTU) || (bus.op == OP_MULT));
    assign is_mt     = bus.op_valid && ((bus.op == OP_MTHI) || (bus.op == OP_MTLO));
    assign is_signed = (bus.op == OP_MULT);

    // Signed multiply runs on magnitudes. Negating 0x80000000 yields 0x80000000,
    // which is the correct unsigned magnitude.
    assign abs_rs = (is_signed && bus.rs_val[31]) ? (~bus.rs_val + 32'd1) : bus.rs_val;
    assign abs_rt = (is_signed && bus.rt_val[31]) ? (~bus.rt_val + 32'd1) : bus.rt_val;
    assign neg_in = is_signed && (bus.rs_val[31] ^ bus.rt_val[31]);

    // Restore the sign of the product (two's complement over 64 bits).
    assign fixed_prod = neg_q ? (~bus.mul_result + 64'd1) : bus.mul_result;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (is_mul) begin
                    state_nxt = bus.mul_busy ? WAIT_FREE : ISSUE;
                end
            end
            WAIT_FREE: begin
                if (!bus.mul_busy) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = ARM;
            end
            ARM: begin
                // The multiplier either raises busy, or it finished with zero
                // latency and never will; the counter bounds the wait.
                if (bus.mul_busy) begin
                    state_nxt = RUN;
                end else if (cnt_q == 2'd3) begin
                    state_nxt = FIX;
                end
            end
            RUN: begin
                if (!bus.mul_busy) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath registers: operand latch, start pulse, ARM counter, HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            neg_q   <= 1'b0;
            cnt_q   <= 2'd0;
            start_q <= 1'b0;
        end else begin
            // Start is high for exactly the cycle spent in ISSUE.
            start_q <= (state_nxt == ISSUE);

            // Operands stay frozen from acceptance through RUN.
            if ((state == IDLE) && is_mul) begin
                a_q   <= abs_rs;
                b_q   <= abs_rt;
                neg_q <= neg_in;
            end

            // Holding the counter at zero outside ARM clears it on entry.
            if (state != ARM) begin
                cnt_q <= 2'd0;
            end else if (cnt_q != 2'd3) begin
                cnt_q <= cnt_q + 2'd1;
            end

            if ((state == IDLE) && is_mt) begin
                if (bus.op == OP_MTLO) begin
                    lo_q <= bus.rs_val;
                end else begin
                    hi_q <= bus.rs_val;
                end
            end else if (state == FIX) begin
                hi_q <= fixed_prod[63:32];
                lo_q <= fixed_prod[31:0];
            end
        end
    end

    // Reads see registered HI/LO, so a same-cycle MTHI/MTLO is not yet visible.
    assign bus.rd_data   = bus.rd_sel ? hi_q : lo_q;
    assign bus.stall     = (state != IDLE) && (bus.op_valid || bus.rd_req);
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.mul_start = start_q;
    assign bus.mul_a     = a_q;
    assign bus.mul_b     = b_q;
endmodule
